// File: rtl/bascomp_pkg.sv
// Shared constants for the basic computer control path: opcodes, sequencer
// phase encoding and the per-opcode execute end count.
package bascomp_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  // Phase encoding is visible on the phase output, so the values are fixed.
  typedef enum logic [2:0] {
    PH_IDLE     = 3'd0,
    PH_FETCH    = 3'd1,
    PH_DECODE   = 3'd2,
    PH_INDIRECT = 3'd3,
    PH_EXECUTE  = 3'd4
  } phase_e;

  // Last fetch timing slot and the runaway-counter value.
  localparam logic [3:0] SC_FETCH_LAST = 4'd1;
  localparam logic [3:0] SC_WATCHDOG   = 4'd15;

  // Timing slot on which the execute phase of an opcode finishes.
  function automatic logic [3:0] end_count(input logic [2:0] op);
    logic [3:0] cnt;
    case (op)
      OP_STA, OP_BUN: cnt = 4'd4;
      OP_ISZ:         cnt = 4'd6;
      OP_REG:         cnt = 4'd3;
      default:        cnt = 4'd5;  // AND, ADD, LDA, BSA
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/timing_decoder.sv
// 4-to-16 one-hot decoder with enable; all outputs low when disabled.
module timing_decoder (
  input  logic        en_i,
  input  logic [3:0]  sel_i,
  output logic [15:0] t_o
);

  // One bit set at the selected position while enabled.
  always_comb begin
    t_o = '0;
    if (en_i) t_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/instruction_cycle_sequencer.sv
// Instruction cycle sequencer: walks fetch/decode/indirect/execute against
// the external sequence counter, decodes T0-T15 and requests counter clears.
// Optional continuity checker built when SEQ_CHECK_EN is defined; otherwise
// seq_err is tied low.
//
// Handshake: enable is a level start request honoured only in IDLE; halt is a
// one-cycle-or-longer stop request latched while running and honoured at the
// end of the current instruction; sc_clr asks the counter to read 0 on the
// following cycle.
module instruction_cycle_sequencer
  import bascomp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  sc_count,
  input  logic        enable,
  input  logic        halt,
  input  logic        ir_i,
  input  logic [2:0]  opcode,
  output logic [15:0] t,
  output logic [2:0]  phase,
  output logic        sc_clr,
  output logic        running,
  output logic        seq_err
);

  phase_e     state_q, state_d;
  logic       halt_q, halt_d;
  logic [2:0] op_q, op_d;
  logic       ind_q, ind_d;
  logic       halt_pend;

  assign running   = (state_q != PH_IDLE);
  assign phase     = state_q;
  assign halt_pend = halt_q | halt;

  timing_decoder u_timing_decoder (
    .en_i  (running),
    .sel_i (sc_count),
    .t_o   (t)
  );

  // Next-state, clear request and captured instruction fields.
  always_comb begin
    state_d = state_q;
    sc_clr  = 1'b0;
    halt_d  = halt_q;
    op_d    = op_q;
    ind_d   = ind_q;

    if (running && halt) halt_d = 1'b1;

    case (state_q)
      PH_IDLE: begin
        sc_clr = 1'b1;
        if (enable && !halt) state_d = PH_FETCH;
      end
      PH_FETCH: begin
        if (sc_count == SC_FETCH_LAST) state_d = PH_DECODE;
      end
      PH_DECODE: begin
        op_d    = opcode;
        ind_d   = ir_i;
        state_d = (opcode != OP_REG && ir_i) ? PH_INDIRECT : PH_EXECUTE;
      end
      PH_INDIRECT: begin
        // Only reachable with the indirect bit captured; an inconsistent
        // entry restarts the fetch rather than executing a bogus address.
        if (ind_q) begin
          state_d = PH_EXECUTE;
        end else begin
          sc_clr  = 1'b1;
          state_d = PH_FETCH;
        end
      end
      PH_EXECUTE: begin
        if (sc_count == end_count(op_q)) begin
          sc_clr  = 1'b1;
          state_d = halt_pend ? PH_IDLE : PH_FETCH;
        end
      end
      default: begin
        sc_clr  = 1'b1;
        state_d = PH_IDLE;
      end
    endcase

    // Runaway counter: restart the instruction from T0.
    if (running && sc_count == SC_WATCHDOG) begin
      sc_clr  = 1'b1;
      state_d = PH_FETCH;
    end

    if (state_d == PH_IDLE) halt_d = 1'b0;
  end

  // State and captured-field registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PH_IDLE;
      halt_q  <= 1'b0;
      op_q    <= 3'd0;
      ind_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      op_q    <= op_d;
      ind_q   <= ind_d;
    end
  end

`ifdef SEQ_CHECK_EN
  logic       prev_clr_q;
  logic [3:0] prev_cnt_q;
  logic       err_q, err_d;
  logic [3:0] exp_cnt;

  assign exp_cnt = prev_clr_q ? 4'd0 : prev_cnt_q + 4'd1;
  assign seq_err = err_q;

  // Sticky fault on any counter discontinuity or watchdog hit while running.
  always_comb begin
    err_d = err_q;
    if (running && (sc_count != exp_cnt || sc_count == SC_WATCHDOG)) err_d = 1'b1;
  end

  // Remember last cycle's counter value and clear request.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_clr_q <= 1'b1;
      prev_cnt_q <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      prev_clr_q <= sc_clr;
      prev_cnt_q <= sc_count;
      err_q      <= err_d;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_cycle_sequencer.sv
// Directed bench for instruction_cycle_sequencer with a modelled sequence
// counter that can be overridden to inject discontinuities.
module tb_instruction_cycle_sequencer;

`ifdef SEQ_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cnt;
  logic        enable, halt, ir_i;
  logic [2:0]  opcode;
  logic [15:0] t;
  logic [2:0]  phase;
  logic        sc_clr, running, seq_err;
  logic        ovr_en;
  logic [3:0]  ovr_val;

  int errors = 0;
  int checks = 0;

  // clock / reset
  always #5 clk = ~clk;

  // sequence counter model
  always @(posedge clk) begin
    if (reset)       cnt <= 4'd0;
    else if (ovr_en) cnt <= ovr_val;
    else if (sc_clr) cnt <= 4'd0;
    else             cnt <= cnt + 4'd1;
  end

  instruction_cycle_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .sc_count (cnt),
    .enable   (enable),
    .halt     (halt),
    .ir_i     (ir_i),
    .opcode   (opcode),
    .t        (t),
    .phase    (phase),
    .sc_clr   (sc_clr),
    .running  (running),
    .seq_err  (seq_err)
  );

  task automatic go_idle();
    bit reached = 1'b0;
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      if (phase === 3'd0) reached = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL go_idle: phase=%0d still not 0 after 40 cycles", phase);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; halt = 1'b0; ir_i = 1'b0; opcode = 3'd0;
    ovr_en = 1'b0; ovr_val = 4'd0;
    repeat (3) @(negedge clk);
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase: got %0d want 0", phase); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++; if (t !== 16'h0000) begin errors++; $display("FAIL reset_t: got %h want 0000", t); end
    checks++; if (sc_clr !== 1'b1) begin errors++; $display("FAIL reset_sc_clr: got %b want 1", sc_clr); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
    reset = 1'b0;
  endtask

  task automatic test_reg_instr();
    logic [2:0]  ph [0:4] = '{3'd1, 3'd1, 3'd2, 3'd4, 3'd1};
    logic [15:0] tt [0:4] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0001};
    logic        cl [0:4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 3'd7; ir_i = 1'b0; enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      enable = 1'b0;
      checks++; if (phase !== ph[k]) begin errors++; $display("FAIL reg_phase[%0d]: got %0d want %0d", k, phase, ph[k]); end
      checks++; if (t !== tt[k]) begin errors++; $display("FAIL reg_t[%0d]: got %h want %h", k, t, tt[k]); end
      checks++; if (sc_clr !== cl[k]) begin errors++; $display("FAIL reg_sc_clr[%0d]: got %b want %b", k, sc_clr, cl[k]); end
    end
    go_idle();
  endtask

  task automatic test_indirect_isz();
    logic [2:0]  ph [0:7] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd1};
    logic [15:0] tt [0:7] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008,
                              16'h0010, 16'h0020, 16'h0040, 16'h0001};
    logic        cl [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    opcode = 3'd6; ir_i = 1'b1; enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      enable = 1'b0;
      checks++; if (phase !== ph[k]) begin errors++; $display("FAIL isz_phase[%0d]: got %0d want %0d", k, phase, ph[k]); end
      checks++; if (t !== tt[k]) begin errors++; $display("FAIL isz_t[%0d]: got %h want %h", k, t, tt[k]); end
      checks++; if (sc_clr !== cl[k]) begin errors++; $display("FAIL isz_sc_clr[%0d]: got %b want %b", k, sc_clr, cl[k]); end
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL isz_seq_err[%0d]: got %b want 0", k, seq_err); end
    end
    go_idle();
  endtask

  task automatic test_halt();
    logic [2:0]  ph [0:6] = '{3'd1, 3'd1, 3'd2, 3'd4, 3'd4, 3'd4, 3'd0};
    logic [15:0] tt [0:6] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008,
                              16'h0010, 16'h0020, 16'h0000};
    logic        cl [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        rn [0:6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    opcode = 3'd1; ir_i = 1'b0; enable = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      enable = 1'b0;
      checks++; if (phase !== ph[k]) begin errors++; $display("FAIL halt_phase[%0d]: got %0d want %0d", k, phase, ph[k]); end
      checks++; if (t !== tt[k]) begin errors++; $display("FAIL halt_t[%0d]: got %h want %h", k, t, tt[k]); end
      checks++; if (sc_clr !== cl[k]) begin errors++; $display("FAIL halt_sc_clr[%0d]: got %b want %b", k, sc_clr, cl[k]); end
      checks++; if (running !== rn[k]) begin errors++; $display("FAIL halt_running[%0d]: got %b want %b", k, running, rn[k]); end
      halt = (k == 0);  // high for the T1 cycle only
    end
    // enable and halt together in IDLE: halt wins
    enable = 1'b1; halt = 1'b1;
    @(negedge clk);
    enable = 1'b0; halt = 1'b0;
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL halt_wins_phase: got %0d want 0", phase); end
    checks++; if (sc_clr !== 1'b1) begin errors++; $display("FAIL halt_wins_sc_clr: got %b want 1", sc_clr); end
  endtask

  task automatic test_discontinuity();
    logic [2:0]  ph [0:5] = '{3'd1, 3'd1, 3'd2, 3'd4, 3'd4, 3'd1};
    logic [15:0] tt [0:5] = '{16'h0001, 16'h0002, 16'h0004, 16'h0010, 16'h0020, 16'h0001};
    logic        cl [0:5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        er [0:5] = '{1'b0, 1'b0, 1'b0, 1'b0, CHK, CHK};
    opcode = 3'd1; ir_i = 1'b0; enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      enable = 1'b0;
      ovr_en = 1'b0;
      checks++; if (phase !== ph[k]) begin errors++; $display("FAIL disc_phase[%0d]: got %0d want %0d", k, phase, ph[k]); end
      checks++; if (t !== tt[k]) begin errors++; $display("FAIL disc_t[%0d]: got %h want %h", k, t, tt[k]); end
      checks++; if (sc_clr !== cl[k]) begin errors++; $display("FAIL disc_sc_clr[%0d]: got %b want %b", k, sc_clr, cl[k]); end
      checks++; if (seq_err !== er[k]) begin errors++; $display("FAIL disc_seq_err[%0d]: got %b want %b", k, seq_err, er[k]); end
      if (k == 2) begin ovr_en = 1'b1; ovr_val = 4'd4; end  // 2 -> 4 jump
    end
    go_idle();
    checks++; if (seq_err !== CHK) begin errors++; $display("FAIL disc_sticky: got %b want %b", seq_err, CHK); end
  endtask

  task automatic test_reset_mid();
    logic [2:0]  ph [0:4] = '{3'd1, 3'd1, 3'd2, 3'd4, 3'd4};
    logic [15:0] tt [0:4] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010};
    logic        cl [0:4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    opcode = 3'd3; ir_i = 1'b0; enable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      enable = 1'b0;
      checks++; if (phase !== ph[k]) begin errors++; $display("FAIL sta_phase[%0d]: got %0d want %0d", k, phase, ph[k]); end
      checks++; if (t !== tt[k]) begin errors++; $display("FAIL sta_t[%0d]: got %h want %h", k, t, tt[k]); end
      checks++; if (sc_clr !== cl[k]) begin errors++; $display("FAIL sta_sc_clr[%0d]: got %b want %b", k, sc_clr, cl[k]); end
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL rst_mid_phase: got %0d want 0", phase); end
    checks++; if (sc_clr !== 1'b1) begin errors++; $display("FAIL rst_mid_sc_clr: got %b want 1", sc_clr); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL rst_mid_seq_err: got %b want 0", seq_err); end
    checks++; if (t !== 16'h0000) begin errors++; $display("FAIL rst_mid_t: got %h want 0000", t); end
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL restart_phase: got %0d want 1", phase); end
    checks++; if (t !== 16'h0001) begin errors++; $display("FAIL restart_t: got %h want 0001", t); end
    @(negedge clk);
    checks++; if (t !== 16'h0002) begin errors++; $display("FAIL restart_t1: got %h want 0002", t); end
    go_idle();
  endtask

  task automatic test_watchdog();
    logic [2:0]  ph [0:3] = '{3'd1, 3'd1, 3'd2, 3'd4};
    logic [15:0] tt [0:3] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
    opcode = 3'd6; ir_i = 1'b0; enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      enable = 1'b0;
      checks++; if (phase !== ph[k]) begin errors++; $display("FAIL wd_phase[%0d]: got %0d want %0d", k, phase, ph[k]); end
      checks++; if (t !== tt[k]) begin errors++; $display("FAIL wd_t[%0d]: got %h want %h", k, t, tt[k]); end
    end
    ovr_en = 1'b1; ovr_val = 4'd15;
    @(negedge clk);
    ovr_en = 1'b0;
    checks++; if (phase !== 3'd4) begin errors++; $display("FAIL wd15_phase: got %0d want 4", phase); end
    checks++; if (t !== 16'h8000) begin errors++; $display("FAIL wd15_t: got %h want 8000", t); end
    checks++; if (sc_clr !== 1'b1) begin errors++; $display("FAIL wd15_sc_clr: got %b want 1", sc_clr); end
    checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL wd15_seq_err: got %b want 0", seq_err); end
    @(negedge clk);
    checks++; if (phase !== 3'd1) begin errors++; $display("FAIL wd_next_phase: got %0d want 1", phase); end
    checks++; if (t !== 16'h0001) begin errors++; $display("FAIL wd_next_t: got %h want 0001", t); end
    checks++; if (seq_err !== CHK) begin errors++; $display("FAIL wd_next_seq_err: got %b want %b", seq_err, CHK); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_reg_instr();
    test_indirect_isz();
    test_halt();
    test_discontinuity();
    test_reset_mid();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at 200000, want finished");
    $fatal(1, "timeout");
  end

endmodule
